sm4_top_level: RTL and testbench

- Iterative SM4 (GB/T 32907) block-cipher engine with a 128-bit key and 128-bit block.
- Runs one round per clock and performs on-chip key expansion into a 32-entry round-key store.
- MODE fixes the block as encryptor or decryptor at elaboration.
- Sits between a key source and a streaming data source/sink.
- No back-pressure: results are presented with a one-cycle valid pulse.

---
 rtl/sm4_pkg.sv | 59 +++++
 rtl/sm4_tau.sv | 11 +
 rtl/sm4_top_level.sv | 151 +++++++++++++++
 tb/tb_sm4_top_level.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 constants, S-box table, linear transforms and FSM state type
// for the iterative SM4 engine.
package sm4_pkg;

  localparam int ROUNDS = 32;

  localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_CRYPT,
    ST_DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // CK_i: byte j (j=0 is the most significant) is ((4i + j) * 7) mod 256.
  function automatic logic [31:0] ck_word(input logic [4:0] idx);
    logic [31:0] w;
    int          v;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      v = ((4 * int'(idx) + j) * 7) % 256;
      w = {w[23:0], 8'(v)};
    end
    return w;
  endfunction

  function automatic logic [31:0] l_data(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 non-linear layer tau: four parallel S-box lookups on a 32-bit word.
module sm4_tau
  import sm4_pkg::*;
(
  input  logic [31:0] i_a,
  output logic [31:0] o_b
);

  assign o_b = {SBOX[i_a[31:24]], SBOX[i_a[23:16]], SBOX[i_a[15:8]], SBOX[i_a[7:0]]};

endmodule

// File: rtl/sm4_top_level.sv
// Iterative SM4 engine: one round per clock, on-chip key expansion into a
// 32-entry round-key store, single tau instance shared by KEYEXP and CRYPT.
module sm4_top_level
  import sm4_pkg::*;
#(
  parameter int           MODE            = 0,
  parameter int           ENABLE_FIXED_RK = 0,
  parameter logic [127:0] FIXED_MK        = 128'h0123456789ABCDEFFEDCBA9876543210
) (
  input  logic         CLK_i,
  input  logic         RST_i,
  input  logic [127:0] MK_i,
  input  logic         MK_VALID_i,
  input  logic [127:0] DAT_i,
  input  logic         DAT_VALID_i,
  output logic [127:0] DAT_o,
  output logic         DAT_READY_o
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [4:0]   r_cnt;
  logic         r_key_ready;
  logic         r_mk_valid_q;
  logic         r_key_pend;
  logic [127:0] r_mk_pend;
  logic [127:0] r_dat;
  logic         r_dat_ready;

  logic [31:0]  r_k  [4];
  logic [31:0]  r_x  [4];
  logic [31:0]  r_rk [ROUNDS];

  logic         w_mk_rise;
  logic         w_key_req;
  logic         w_start_key;
  logic         w_start_blk;
  logic [127:0] w_key_mk;
  logic [4:0]   w_rk_idx;
  logic [31:0]  w_tau_in;
  logic [31:0]  w_tau_out;
  logic [31:0]  w_rk_new;
  logic [31:0]  w_x_new;

  assign w_mk_rise   = (ENABLE_FIXED_RK == 0) && MK_VALID_i && !r_mk_valid_q;
  assign w_key_req   = w_mk_rise || r_key_pend;
  assign w_start_key = (r_state == ST_IDLE) && w_key_req;
  assign w_start_blk = (r_state == ST_IDLE) && !w_key_req && r_key_ready && DAT_VALID_i;
  assign w_key_mk    = (ENABLE_FIXED_RK != 0) ? FIXED_MK : (w_mk_rise ? MK_i : r_mk_pend);
  assign w_rk_idx    = (MODE != 0) ? (5'd31 - r_cnt) : r_cnt;

  // KEYEXP and CRYPT never overlap, so one tau serves both.
  assign w_tau_in = (r_state == ST_KEYEXP) ? (r_k[1] ^ r_k[2] ^ r_k[3] ^ ck_word(r_cnt))
                                           : (r_x[1] ^ r_x[2] ^ r_x[3] ^ r_rk[w_rk_idx]);

  sm4_tau u_tau (
    .i_a (w_tau_in),
    .o_b (w_tau_out)
  );

  assign w_rk_new = r_k[0] ^ l_key(w_tau_out);
  assign w_x_new  = r_x[0] ^ l_data(w_tau_out);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_key)      w_state_nxt = ST_KEYEXP;
        else if (w_start_blk) w_state_nxt = ST_CRYPT;
      end
      ST_KEYEXP: if (r_cnt == 5'd31) w_state_nxt = ST_IDLE;
      ST_CRYPT:  if (r_cnt == 5'd31) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_key_ready  <= 1'b0;
      r_mk_valid_q <= 1'b0;
      r_key_pend   <= (ENABLE_FIXED_RK != 0);
      r_mk_pend    <= '0;
      r_dat        <= '0;
      r_dat_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mk_valid_q <= MK_VALID_i;
      r_dat_ready  <= 1'b0;

      if (w_start_key) begin
        r_key_pend  <= 1'b0;
        r_key_ready <= 1'b0;
        r_cnt       <= '0;
      end else if (w_start_blk) begin
        r_cnt <= '0;
      end else if (r_state == ST_KEYEXP || r_state == ST_CRYPT) begin
        r_cnt <= r_cnt + 5'd1;
      end

      if (r_state == ST_KEYEXP && r_cnt == 5'd31) r_key_ready <= 1'b1;

      if (r_state == ST_DONE) begin
        r_dat       <= {r_x[3], r_x[2], r_x[1], r_x[0]};
        r_dat_ready <= 1'b1;
      end

      // A key request outside IDLE is held until the engine is free again.
      if (w_mk_rise && r_state != ST_IDLE) begin
        r_key_pend <= 1'b1;
        r_mk_pend  <= MK_i;
      end
    end
  end

  // NOTE: datapath registers and the round-key store carry no reset; they are always loaded before use.
  always_ff @(posedge CLK_i) begin
    if (w_start_key) begin
      r_k[0] <= w_key_mk[127:96] ^ FK[0];
      r_k[1] <= w_key_mk[95:64]  ^ FK[1];
      r_k[2] <= w_key_mk[63:32]  ^ FK[2];
      r_k[3] <= w_key_mk[31:0]   ^ FK[3];
    end else if (r_state == ST_KEYEXP) begin
      r_k[0]       <= r_k[1];
      r_k[1]       <= r_k[2];
      r_k[2]       <= r_k[3];
      r_k[3]       <= w_rk_new;
      r_rk[r_cnt]  <= w_rk_new;
    end

    if (w_start_blk) begin
      r_x[0] <= DAT_i[127:96];
      r_x[1] <= DAT_i[95:64];
      r_x[2] <= DAT_i[63:32];
      r_x[3] <= DAT_i[31:0];
    end else if (r_state == ST_CRYPT) begin
      r_x[0] <= r_x[1];
      r_x[1] <= r_x[2];
      r_x[2] <= r_x[3];
      r_x[3] <= w_x_new;
    end
  end

  assign DAT_o       = r_dat;
  assign DAT_READY_o = r_dat_ready;

endmodule

// File: tb/tb_sm4_top_level.sv
// Self-checking bench for sm4_top_level: encryptor, decryptor and fixed-key
// instances, a per-instance expected-result queue and a behavioural SM4 model.
module tb_sm4_top_level;
  import sm4_pkg::*;

  localparam logic [127:0] P   = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KAT = 128'h681EDF34D206965E86B3E94F536E4246;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         CLK_i;
  logic         RST_i;
  logic [127:0] mk_e, mk_d, mk_f, dat_e, dat_d, dat_f;
  logic         mkv_e, mkv_d, mkv_f, datv_e, datv_d, datv_f;
  logic [127:0] out_e, out_d, out_f;
  logic         rdy_e, rdy_d, rdy_f;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           stab_err = 0;
  int           cyc      = 0;
  logic [127:0] q_exp [3][$];
  int           pc [$];
  logic         prev_rdy [3];
  logic [127:0] last_dat [3];
  vec_t         vecs [4];

  sm4_top_level #(.MODE(0), .ENABLE_FIXED_RK(0)) u_enc (
    .CLK_i(CLK_i), .RST_i(RST_i), .MK_i(mk_e), .MK_VALID_i(mkv_e),
    .DAT_i(dat_e), .DAT_VALID_i(datv_e), .DAT_o(out_e), .DAT_READY_o(rdy_e));

  sm4_top_level #(.MODE(1), .ENABLE_FIXED_RK(0)) u_dec (
    .CLK_i(CLK_i), .RST_i(RST_i), .MK_i(mk_d), .MK_VALID_i(mkv_d),
    .DAT_i(dat_d), .DAT_VALID_i(datv_d), .DAT_o(out_d), .DAT_READY_o(rdy_d));

  sm4_top_level #(.MODE(0), .ENABLE_FIXED_RK(1)) u_fix (
    .CLK_i(CLK_i), .RST_i(RST_i), .MK_i(mk_f), .MK_VALID_i(mkv_f),
    .DAT_i(dat_f), .DAT_VALID_i(datv_f), .DAT_o(out_f), .DAT_READY_o(rdy_f));

  initial CLK_i = 1'b0;
  always #5 CLK_i = ~CLK_i;
  always @(posedge CLK_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] ref_sm4(input logic [127:0] key, input logic [127:0] blk, input bit dec);
    logic [31:0]  k [36];
    logic [31:0]  x [36];
    logic [31:0]  rk [32];
    logic [31:0]  t, ck;
    logic [127:0] fkw;
    fkw = 128'hA3B1BAC656AA3350677D9197B27022DC;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127 - 32*i -: 32] ^ fkw[127 - 32*i -: 32];
      x[i] = blk[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
      t = tb_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rl(t, 13) ^ rl(t, 23);
      rk[i] = k[i+4];
    end
    for (int i = 0; i < 32; i++) begin
      t = tb_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
      x[i+4] = x[i] ^ t ^ rl(t, 2) ^ rl(t, 10) ^ rl(t, 18) ^ rl(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic mon(input int id, input logic rdy, input logic [127:0] dat);
    logic [127:0] exp_v;
    if (RST_i) begin
      prev_rdy[id] = 1'b0;
      last_dat[id] = '0;
      return;
    end
    if (rdy) begin
      check($sformatf("pulse_width_%0d", id), 128'(prev_rdy[id]), 128'(0));
      if (id == 0) pc.push_back(cyc);
      if (q_exp[id].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse_%0d: got %h expected no pulse", id, dat);
      end else begin
        exp_v = q_exp[id].pop_front();
        check($sformatf("dat_%0d", id), dat, exp_v);
      end
      last_dat[id] = dat;
    end else if (dat !== last_dat[id]) begin
      stab_err++;
    end
    prev_rdy[id] = rdy;
  endtask

  always @(negedge CLK_i) begin
    mon(0, rdy_e, out_e);
    mon(1, rdy_d, out_d);
    mon(2, rdy_f, out_f);
  end

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge CLK_i);
      if (rdy_e) got++;
    end
    datv_e = 1'b0;
    datv_d = 1'b0;
    datv_f = 1'b0;
    check(name, 128'(got), 128'(n));
  endtask

  task automatic wait_empty(input int budget, input string name);
    int left;
    left = q_exp[0].size() + q_exp[1].size() + q_exp[2].size();
    for (int c = 0; c < budget && left != 0; c++) begin
      tick();
      left = q_exp[0].size() + q_exp[1].size() + q_exp[2].size();
    end
    check(name, 128'(left), 128'(0));
  endtask

  initial begin
    int           rel;
    logic [127:0] pta, ptb, k2;

    vecs[0] = '{key: P, pt: P, ct: KAT};
    vecs[1] = '{key: P, pt: {$urandom, $urandom, $urandom, $urandom}, ct: '0};
    vecs[2] = '{key: {$urandom, $urandom, $urandom, $urandom}, pt: {$urandom, $urandom, $urandom, $urandom}, ct: '0};
    vecs[3] = '{key: {$urandom, $urandom, $urandom, $urandom}, pt: {$urandom, $urandom, $urandom, $urandom}, ct: '0};
    for (int i = 1; i < 4; i++) vecs[i].ct = ref_sm4(vecs[i].key, vecs[i].pt, 1'b0);
    check("model_kat", ref_sm4(P, P, 1'b0), KAT);

    // Reset with keys requested and data offered from the start.
    RST_i = 1'b1;
    mk_e = P;  mkv_e = 1'b1; dat_e = P;   datv_e = 1'b1;
    mk_d = P;  mkv_d = 1'b1; dat_d = KAT; datv_d = 1'b1;
    mk_f = 128'hDEADBEEF_CAFEF00D_55AA55AA_12345678; mkv_f = 1'b0; dat_f = P; datv_f = 1'b1;
    repeat (3) tick();
    check("rst_dat_enc", out_e, '0);
    check("rst_rdy_enc", 128'(rdy_e), 128'(0));
    check("rst_dat_dec", out_d, '0);
    check("rst_rdy_dec", 128'(rdy_d), 128'(0));
    check("rst_dat_fix", out_f, '0);
    check("rst_rdy_fix", 128'(rdy_f), 128'(0));

    for (int i = 0; i < 3; i++) begin
      q_exp[0].push_back(KAT);
      q_exp[1].push_back(P);
      q_exp[2].push_back(KAT);
    end
    pc.delete();
    RST_i = 1'b0;
    rel = cyc;
    wait_pulses(3, 200, "stream_pulses");
    wait_empty(5, "stream_drain");
    if (pc.size() >= 3) begin
      check("first_latency", 128'(pc[0] - rel), 128'(67));
      check("interval_1", 128'(pc[1] - pc[0]), 128'(34));
      check("interval_2", 128'(pc[2] - pc[1]), 128'(34));
    end else begin
      check("stream_pulse_count", 128'(pc.size()), 128'(3));
    end
    check("rk0", 128'(u_enc.r_rk[0]), 128'(32'hF12186F9));
    check("rk31", 128'(u_enc.r_rk[31]), 128'(32'h9124A012));

    // Table: load each key into both engines, encrypt and decrypt one block.
    for (int i = 0; i < 4; i++) begin
      mkv_e = 1'b0; mkv_d = 1'b0;
      tick();
      mk_e = vecs[i].key; mk_d = vecs[i].key;
      mkv_e = 1'b1; mkv_d = 1'b1;
      repeat (36) tick();
      dat_e = vecs[i].pt; datv_e = 1'b1; q_exp[0].push_back(vecs[i].ct);
      dat_d = vecs[i].ct; datv_d = 1'b1; q_exp[1].push_back(vecs[i].pt);
      tick();
      datv_e = 1'b0; datv_d = 1'b0;
      wait_empty(60, $sformatf("vec_%0d_done", i));
    end

    // Reset during round 15 of a block under the last table key.
    dat_e = {$urandom, $urandom, $urandom, $urandom};
    datv_e = 1'b1;
    tick();
    datv_e = 1'b0;
    repeat (15) tick();
    RST_i = 1'b1;
    #1;
    check("midrst_dat_enc", out_e, '0);
    check("midrst_rdy_enc", 128'(rdy_e), 128'(0));
    check("midrst_dat_dec", out_d, '0);
    mk_e = P; dat_e = P; datv_e = 1'b1;
    q_exp[0].push_back(KAT);
    repeat (2) tick();
    pc.delete();
    RST_i = 1'b0;
    rel = cyc;
    wait_pulses(1, 120, "postrst_pulse");
    if (pc.size() >= 1) check("postrst_latency", 128'(pc[0] - rel), 128'(67));
    wait_empty(5, "postrst_drain");

    // New key arrives mid-CRYPT: block A keeps the old key, block B uses the new one.
    mkv_e = 1'b0;
    tick();
    pta = {$urandom, $urandom, $urandom, $urandom};
    ptb = {$urandom, $urandom, $urandom, $urandom};
    k2  = {$urandom, $urandom, $urandom, $urandom};
    dat_e = pta; datv_e = 1'b1; q_exp[0].push_back(ref_sm4(P, pta, 1'b0));
    tick();
    datv_e = 1'b0;
    repeat (10) tick();
    mk_e = k2; mkv_e = 1'b1;
    dat_e = ptb; datv_e = 1'b1; q_exp[0].push_back(ref_sm4(k2, ptb, 1'b0));
    wait_pulses(2, 250, "rekey_pulses");
    wait_empty(5, "rekey_drain");

    repeat (40) tick();
    check("dat_stable", 128'(stab_err), 128'(0));
    check("queues_empty", 128'(q_exp[0].size() + q_exp[1].size() + q_exp[2].size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
